fmadd_mantissa_mult_seq: RTL and testbench
==========================================

FMADD_MANTISSA_MULT_SEQ -- requirements
Module: fmadd_mantissa_mult_seq

Parameters
REQ-001 The block SHALL have parameter MAN, default 7, giving mantissa field width; operand width W = MAN+2, product width P = 2*MAN+4.
REQ-002 The block SHALL have parameter BPC, default 2, giving multiplier bits retired per cycle; legal values are 1, 2 and 4.
REQ-003 The iteration count SHALL be ITER = ceil(W/BPC); the multiplier SHALL be zero-padded on the MSB side to ITER*BPC bits.

Interface
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_l  input  1  asynchronous active-low reset.
REQ-006 Mantissa_Mult_input_A  input  W  multiplicand.
REQ-007 Mantissa_Mult_input_B  input  W  multiplier.
REQ-008 Mantissa_Mult_input_Activation_Signal  input  1  when low at accept, the result is forced to zero.
REQ-009 Mantissa_Mult_input_Valid  input  1  the operands and activation signal are valid.
REQ-010 Mantissa_Mult_output_Ready  output  1  the block can accept operands.
REQ-011 Mantissa_Mult_input_Flush  input  1  synchronous abort of the current operation.
REQ-012 Mantissa_Mult_output_Mantissa  output  P  unsigned product A*B.
REQ-013 Mantissa_Mult_output_Valid  output  1  the product is valid.
REQ-014 Mantissa_Mult_input_Out_Ready  input  1  the consumer accepts the product.
REQ-015 Mantissa_Mult_output_Busy  output  1  the block is in state BUSY.

Function
REQ-016 FSM states SHALL be IDLE, BUSY and DONE; Output_Ready = (state==IDLE); Busy = (state==BUSY); output_Valid = (state==DONE).
REQ-017 An accept SHALL occur on a rising edge where state==IDLE and input_Valid=1 and Flush=0; the block SHALL capture A, B and activation at that edge.
REQ-018 At accept with activation=0, or A==0, or B==0, the block SHALL load product 0 and go directly to DONE; Valid is therefore visible 1 cycle after the accept edge.
REQ-019 In all other accepts the block SHALL clear the accumulator, set the iteration counter to 0 and go to BUSY.
REQ-020 Each BUSY cycle SHALL add (A * next BPC multiplier bits, LSB first) shifted by counter*BPC into the P-bit accumulator and increment the counter.
REQ-021 After the ITER-th BUSY edge the block SHALL go to DONE; Valid is visible exactly ITER+1 edges after the accept edge (BPC=2, MAN=7: 6 edges).
REQ-022 The accumulator SHALL never overflow P bits; the final product SHALL equal A*B exactly for all operands.
REQ-023 In DONE, Mantissa and Valid SHALL hold stable until an edge with Out_Ready=1; that edge SHALL return the FSM to IDLE.
REQ-024 There SHALL be no accept in the same edge as the DONE->IDLE transition, because Output_Ready is low in DONE.
REQ-025 input_Valid or operand changes while the FSM is in BUSY or DONE SHALL be ignored.
REQ-026 Flush=1 on any edge SHALL force IDLE, clear the counter and accumulator, and take priority over accept and over the DONE handshake.
REQ-027 Output_Mantissa SHALL read 0 in every state except DONE.

Reset
REQ-028 When rst_l=0, the block SHALL immediately and asynchronously enter IDLE with counter 0, accumulator 0 and all operand registers 0.
REQ-029 During reset the outputs SHALL be Output_Ready=1, Valid=0, Busy=0 and Mantissa=0.
REQ-030 Reset asserted during BUSY or DONE SHALL discard the operation; no Valid pulse SHALL follow the deassertion of reset.

Verification (MAN=7, W=9, P=18)
REQ-031 BPC=2, activation=1, A=0x180, B=0x180, Out_Ready=1 -> Valid high 6 edges after accept, Mantissa=0x24000, then IDLE.
REQ-032 BPC=1, A=0x1FF, B=0x1FF -> Busy for 9 cycles, Mantissa=0x3FC01; with BPC=4 -> same value after 3 BUSY cycles.
REQ-033 activation=0, A=0x1FF, B=0x1FF; separately A=0 -> Valid 1 edge after accept, Mantissa=0, Busy never asserted.
REQ-034 Hold Out_Ready=0 for 5 cycles in DONE while driving new input_Valid -> Mantissa/Valid stable, no accept; first Out_Ready=1 edge -> IDLE, next accept succeeds.
REQ-035 Flush at the 3rd BUSY cycle -> IDLE next edge, Valid never asserted; immediate new accept of 0x100*0x002 -> 0x00200.
REQ-036 Pulse rst_l low mid-BUSY and in DONE -> outputs go to their reset values with no clock edge; no stale Valid after deassertion.

Source files
------------

// File: rtl/fmadd_mantissa_mult_seq.sv
// Sequential unsigned mantissa multiplier for the FMADD datapath.
// Retires BPC multiplier bits per cycle using a shift-and-add loop,
// with a ready/valid handshake on both sides and a synchronous flush.
module fmadd_mantissa_mult_seq #(
    parameter int MAN = 7,
    parameter int BPC = 2
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic [MAN+1:0]       Mantissa_Mult_input_A,
    input  logic [MAN+1:0]       Mantissa_Mult_input_B,
    input  logic                 Mantissa_Mult_input_Activation_Signal,
    input  logic                 Mantissa_Mult_input_Valid,
    output logic                 Mantissa_Mult_output_Ready,
    input  logic                 Mantissa_Mult_input_Flush,
    output logic [2*MAN+3:0]     Mantissa_Mult_output_Mantissa,
    output logic                 Mantissa_Mult_output_Valid,
    input  logic                 Mantissa_Mult_input_Out_Ready,
    output logic                 Mantissa_Mult_output_Busy
);

    localparam int W    = MAN + 2;
    localparam int P    = 2 * MAN + 4;
    localparam int ITER = (W + BPC - 1) / BPC;
    localparam int BW   = ITER * BPC;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [P-1:0]    acc;
    logic [P-1:0]    a_sh;     // multiplicand, pre-shifted by cnt*BPC
    logic [BW-1:0]   b_sh;     // multiplier, zero-padded, consumed LSB first
    logic            accept;
    logic            zero_op;
    logic            last_iter;

    // One BPC-bit multiplier digit times the aligned multiplicand.
    // A*B fits in 2*W = P bits, so no partial sum can overflow the accumulator.
    function automatic logic [P-1:0] partial_product(input logic [P-1:0]   a,
                                                     input logic [BPC-1:0] d);
        return a * {{(P-BPC){1'b0}}, d};
    endfunction

    assign accept    = (state == IDLE) && Mantissa_Mult_input_Valid && !Mantissa_Mult_input_Flush;
    assign zero_op   = !Mantissa_Mult_input_Activation_Signal ||
                       (Mantissa_Mult_input_A == '0) || (Mantissa_Mult_input_B == '0);
    assign last_iter = (cnt == CW'(ITER - 1));

    assign Mantissa_Mult_output_Ready    = (state == IDLE);
    assign Mantissa_Mult_output_Busy     = (state == BUSY);
    assign Mantissa_Mult_output_Valid    = (state == DONE);
    assign Mantissa_Mult_output_Mantissa = (state == DONE) ? acc : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = zero_op ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (Mantissa_Mult_input_Out_Ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (Mantissa_Mult_input_Flush) begin
            state_nxt = IDLE;
        end
    end

    // Operand capture, iteration counter and shift-and-add accumulator.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt  <= '0;
            acc  <= '0;
            a_sh <= '0;
            b_sh <= '0;
        end else if (Mantissa_Mult_input_Flush) begin
            cnt  <= '0;
            acc  <= '0;
            a_sh <= '0;
            b_sh <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt  <= '0;
                        acc  <= '0;
                        a_sh <= P'(Mantissa_Mult_input_A);
                        b_sh <= BW'(Mantissa_Mult_input_B);
                    end
                end
                BUSY: begin
                    acc  <= acc + partial_product(a_sh, b_sh[BPC-1:0]);
                    a_sh <= a_sh << BPC;
                    b_sh <= b_sh >> BPC;
                    cnt  <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmadd_mantissa_mult_seq.sv
// Self-checking bench for fmadd_mantissa_mult_seq (MAN=7, W=9, P=18).
// Main instance uses BPC=2; two side instances cover BPC=1 and BPC=4.
module tb_fmadd_mantissa_mult_seq;

    localparam int ITER2 = 5;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [8:0]  a, b;
    logic        act, vld, flush, out_rdy, aux_vld;

    logic        rdy, ovld, busy;
    logic [17:0] mant;
    logic        rdy1, ovld1, busy1;
    logic [17:0] mant1;
    logic        rdy4, ovld4, busy4;
    logic [17:0] mant4;

    int n_chk  = 0;
    int n_pass = 0;
    logic [17:0] sb[$];

    always #5 clk = ~clk;

    fmadd_mantissa_mult_seq #(.MAN(7), .BPC(2)) dut (
        .clk(clk), .rst_l(rst_l),
        .Mantissa_Mult_input_A(a), .Mantissa_Mult_input_B(b),
        .Mantissa_Mult_input_Activation_Signal(act),
        .Mantissa_Mult_input_Valid(vld),
        .Mantissa_Mult_output_Ready(rdy),
        .Mantissa_Mult_input_Flush(flush),
        .Mantissa_Mult_output_Mantissa(mant),
        .Mantissa_Mult_output_Valid(ovld),
        .Mantissa_Mult_input_Out_Ready(out_rdy),
        .Mantissa_Mult_output_Busy(busy)
    );

    fmadd_mantissa_mult_seq #(.MAN(7), .BPC(1)) dut_bpc1 (
        .clk(clk), .rst_l(rst_l),
        .Mantissa_Mult_input_A(a), .Mantissa_Mult_input_B(b),
        .Mantissa_Mult_input_Activation_Signal(act),
        .Mantissa_Mult_input_Valid(aux_vld),
        .Mantissa_Mult_output_Ready(rdy1),
        .Mantissa_Mult_input_Flush(flush),
        .Mantissa_Mult_output_Mantissa(mant1),
        .Mantissa_Mult_output_Valid(ovld1),
        .Mantissa_Mult_input_Out_Ready(1'b1),
        .Mantissa_Mult_output_Busy(busy1)
    );

    fmadd_mantissa_mult_seq #(.MAN(7), .BPC(4)) dut_bpc4 (
        .clk(clk), .rst_l(rst_l),
        .Mantissa_Mult_input_A(a), .Mantissa_Mult_input_B(b),
        .Mantissa_Mult_input_Activation_Signal(act),
        .Mantissa_Mult_input_Valid(aux_vld),
        .Mantissa_Mult_output_Ready(rdy4),
        .Mantissa_Mult_input_Flush(flush),
        .Mantissa_Mult_output_Mantissa(mant4),
        .Mantissa_Mult_output_Valid(ovld4),
        .Mantissa_Mult_input_Out_Ready(1'b1),
        .Mantissa_Mult_output_Busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every product handed off by the main instance must match the queue head.
    always @(negedge clk) begin
        if (rst_l && ovld && out_rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("product", mant, sb.pop_front());
            end
        end
    end

    // One full transaction on the main instance with Out_Ready held high.
    task automatic run_op(input logic [8:0] ia, input logic [8:0] ib, input logic iact);
        logic [17:0] expv;
        int lat, nbusy, exp_lat;
        expv    = iact ? (18'(ia) * 18'(ib)) : 18'd0;
        exp_lat = (!iact || ia == 0 || ib == 0) ? 1 : ITER2 + 1;
        chk("ready_before_accept", rdy, 1);
        a = ia; b = ib; act = iact; vld = 1'b1;
        sb.push_back(expv);
        @(posedge clk); #1;
        vld = 1'b0; lat = 1; nbusy = 0;
        while (!ovld && lat < 40) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("busy_cycles", nbusy, exp_lat - 1);
        @(posedge clk); #1;
        chk("idle_after_handoff", rdy, 1);
        chk("valid_low_after_handoff", ovld, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, rdy, 1);
        chk({tag, "_valid"}, ovld, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mant"}, mant, 0);
    endtask

    task automatic no_valid_for(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (ovld) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb1, nb4, lat1, lat4, cyc;
        logic got1, got4;
        logic [17:0] m1, m4, hold_exp;

        rst_l = 1'b0; a = '0; b = '0; act = 1'b0; vld = 1'b0;
        flush = 1'b0; out_rdy = 1'b1; aux_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_l = 1'b1;
        @(posedge clk); #1;

        // Directed and corner products
        run_op(9'h180, 9'h180, 1'b1);
        run_op(9'h1FF, 9'h1FF, 1'b1);
        run_op(9'h1FF, 9'h001, 1'b1);
        run_op(9'h001, 9'h1FF, 1'b1);
        run_op(9'h100, 9'h100, 1'b1);
        run_op(9'h1FF, 9'h1FF, 1'b0);
        run_op(9'h000, 9'h1FF, 1'b1);
        run_op(9'h0AB, 9'h000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            run_op(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                   1'($urandom_range(0, 3) != 0));
        end

        // Side instances: BPC=1 and BPC=4 on 0x1FF * 0x1FF
        a = 9'h1FF; b = 9'h1FF; act = 1'b1; aux_vld = 1'b1;
        @(posedge clk); #1;
        aux_vld = 1'b0;
        nb1 = 0; nb4 = 0; lat1 = 0; lat4 = 0; got1 = 0; got4 = 0; m1 = '0; m4 = '0;
        cyc = 1;
        while (!(got1 && got4) && cyc < 30) begin
            if (busy1) nb1++;
            if (busy4) nb4++;
            if (ovld1 && !got1) begin got1 = 1'b1; lat1 = cyc; m1 = mant1; end
            if (ovld4 && !got4) begin got4 = 1'b1; lat4 = cyc; m4 = mant4; end
            @(posedge clk); #1;
            cyc++;
        end
        chk("bpc1_busy_cycles", nb1, 9);
        chk("bpc1_latency", lat1, 10);
        chk("bpc1_product", m1, 18'h3FC01);
        chk("bpc4_busy_cycles", nb4, 3);
        chk("bpc4_latency", lat4, 4);
        chk("bpc4_product", m4, 18'h3FC01);
        repeat (2) @(posedge clk);
        #1;

        // Consumer stall in DONE while new operands are offered
        out_rdy = 1'b0;
        hold_exp = 18'(9'h0AB) * 18'(9'h155);
        a = 9'h0AB; b = 9'h155; act = 1'b1; vld = 1'b1;
        sb.push_back(hold_exp);
        @(posedge clk); #1;
        vld = 1'b0;
        cyc = 0;
        while (!ovld && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold_valid_reached", ovld, 1);
        for (int i = 0; i < 5; i++) begin
            a = 9'($urandom_range(1, 511)); b = 9'($urandom_range(1, 511));
            act = 1'b1; vld = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid", ovld, 1);
            chk("hold_mant", mant, hold_exp);
            chk("hold_ready_low", rdy, 0);
        end
        vld = 1'b0; out_rdy = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_idle", rdy, 1);
        chk("hold_release_valid_low", ovld, 0);
        run_op(9'h100, 9'h003, 1'b1);

        // Flush on the third BUSY cycle
        a = 9'h1FF; b = 9'h1FF; act = 1'b1; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("flush_pre_busy", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_reset_outputs("flush");
        run_op(9'h100, 9'h002, 1'b1);
        chk("flush_followup_sb_empty", sb.size(), 0);

        // Asynchronous reset in BUSY
        a = 9'h1FF; b = 9'h1FF; act = 1'b1; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy_pre", busy, 1);
        #2 rst_l = 1'b0;
        #1;
        check_reset_outputs("rst_in_busy");
        @(posedge clk); #1;
        rst_l = 1'b1;
        no_valid_for("rst_busy_no_stale_valid", 12);

        // Asynchronous reset in DONE
        out_rdy = 1'b0;
        a = 9'h0F0; b = 9'h00F; act = 1'b1; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        cyc = 0;
        while (!ovld && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_done_pre_valid", ovld, 1);
        #2 rst_l = 1'b0;
        #1;
        check_reset_outputs("rst_in_done");
        @(posedge clk); #1;
        rst_l = 1'b1;
        out_rdy = 1'b1;
        no_valid_for("rst_done_no_stale_valid", 12);

        run_op(9'h155, 9'h0AA, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
